dma_copy: RTL and testbench
===========================

# dma_copy

Word-granular block-copy engine and bus initiator for the shared 32-bit address/data bus. When started, it requests the bus from the core and moves `len` bytes from `src` to `dst` as single-word read/write strobe pairs, using the same level-sensitive `read`/`write` protocol the byte-addressed memory responds to. It sits beside the core on `addr`/`bus`. The top level merges its split output/enable ports into the tri-state nets.

## Interface
- `WAIT_STATES`, default 0: extra cycles each read and write strobe is held; range 0–15.
- `clk` input 1: clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `src` input 32: source byte address, latched on accepted `start`.
- `dst` input 32: destination byte address, latched on accepted `start`.
- `len` input 32: byte count, latched; `len[1:0]` ignored; word count = `len>>2`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on completion.
- `bus_req` output 1: requests ownership of `addr`/`bus`.
- `bus_gnt` input 1: ownership granted by the core.
- `addr_out` output 32: address to drive.
- `addr_oe` output 1: drive `addr_out` onto `addr`.
- `data_out` output 32: write data.
- `data_oe` output 1: drive `data_out` onto `bus`.
- `data_in` input 32: `bus` as seen by the block.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe; the top level ANDs it with `clk` as for the core.

## Operation
- **States:** IDLE, REQ, RD, WR, DONE.
- **IDLE:**
  - `start`=1 latches the source pointer, destination pointer and word counter.
  - Word count 0 → DONE. Otherwise → REQ.
  - `start` outside IDLE is ignored.
- **REQ:** `bus_req`=1. On `bus_gnt`=1 → RD (or WR in fill mode).
- **RD:**
  - `addr_out`=source pointer, `addr_oe`=1, `mem_read`=1, held for 1+`WAIT_STATES` cycles.
  - The data register captures `data_in` on the final edge.
  - → WR.
- **WR:**
  - `addr_out`=destination pointer, `data_out`=data register, `addr_oe`=`data_oe`=`mem_write`=1, held for 1+`WAIT_STATES` cycles.
  - On the final edge: both pointers +4, counter −1.
  - Counter now 0 → DONE.
  - Else, `bus_gnt`=1 → RD.
  - Else → REQ, keeping pointers and counter.
- **DONE:** `done`=1 for one cycle, `bus_req`=0 → IDLE.
- **Grant loss:** `bus_gnt` dropping mid-word does not abort the word. The current RD/WR pair completes and grant is rechecked only at word boundaries.
- **Wrap-around:** pointers wrap modulo 2^32.
- **Direction:** copy is ascending with no overlap correction. With `dst`=`src`+4, the first word is replicated throughout.
- **Idle outputs:** all enables and strobes are 0 in IDLE, REQ and DONE.
- **Bus request:** `bus_req` is 1 in REQ, RD and WR.

## Timing
- **Reset:** `rst` forces IDLE immediately. All outputs go to 0: `busy`, `done`, `bus_req`, all `*_oe`, `mem_read`, `mem_write`, `addr_out`, `data_out`. Pointers, counter and data register clear. A reset mid-transfer abandons the copy; a partly written word is not repaired.
- **Start latency:** `start` sampled at edge N → REQ from N+1 (`bus_req`=1). Grant sampled at edge M → first strobe from M+1.
- **Throughput:** 2×(1+`WAIT_STATES`) cycles per word with grant held. N words take 1 + 1 + 2N(1+`WAIT_STATES`) + 1 cycles from `start` to the end of the `done` pulse, with grant already high.
- **Zero length:** `len`<4 gives `done` at N+1, `bus_req` never asserted.
- **Registered outputs:** all outputs are registered or decoded from state only; no combinational path from `bus_gnt` or `data_in` to outputs.

## Configuration
- **`DMA_COPY_FILL_EN` defined:**
  - Adds inputs `fill` (1) and `fill_val` (32), both latched with `start`.
  - `fill`=1 skips RD: WR writes `fill_val` to successive destination words at 1+`WAIT_STATES` cycles per word, and `mem_read` is never asserted.
  - `fill`=0 behaves as a normal copy.
- **Undefined:** the ports are absent and the block always copies.

## Structure
- `dma_pkg` holds:
  - state enum `dma_state_t` (IDLE, REQ, RD, WR, DONE);
  - `DMA_WORD_BYTES`=4;
  - `DMA_WAIT_W`=4.
- One sub-module, `dma_wait_ctr`: loadable down-counter producing the last-strobe-cycle flag. It reloads on entry to RD/WR; with `WAIT_STATES`=0 the flag is constantly 1.

## Test plan
- **Single word:** memory word 0x100 = 0xDEADBEEF; start src=0x100, dst=0x200, len=4, grant tied high → 0x200 reads 0xDEADBEEF. `done` pulses exactly 4 cycles after `start`; `mem_read` and `mem_write` each high exactly 1 cycle.
- **Multi-word with wait states:** `WAIT_STATES`=2, len=16, src=0x0, dst=0x40 → 4 words copied in order, each strobe held 3 cycles, 24 strobe cycles total.
- **Grant withdrawal:** `bus_gnt` dropped during the RD of word 1 of 3 → word 1 completes, block parks in REQ with no drives. Restoring grant resumes at word 2 and all 3 words are correct.
- **Zero and odd length:** len=0 and len=3 → `done` 1 cycle after `start`, no `bus_req`. len=7 copies exactly one word.
- **Reset and start handling:** async `rst` pulse during WR of word 2 → all outputs 0 without a clock edge, `busy`=0. A new `start` afterwards runs normally. `start` while `busy` has no effect.
- **Fill mode:** with `DMA_COPY_FILL_EN`, fill=1, fill_val=0xA5A5A5A5, dst=0x300, len=8 → 0x300 and 0x304 hold 0xA5A5A5A5, `mem_read` never high, `done` 4 cycles after `start`.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared state encoding and constants for the dma_copy block-copy engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    DONE
  } dma_state_t;

  localparam int DMA_WORD_BYTES = 4;
  localparam int DMA_WAIT_W     = 4;
  localparam int DMA_CNT_W      = 30;

  // Byte length to whole-word count; the two low bits are dropped.
  function automatic logic [DMA_CNT_W-1:0] word_count(input logic [31:0] len);
    return DMA_CNT_W'(len >> 2);
  endfunction

endpackage

// File: rtl/dma_wait_ctr.sv
// Loadable down-counter that flags the final cycle of a held bus strobe.
// Reloaded on entry to each strobe phase; with zero wait states the flag stays high.
module dma_wait_ctr
  import dma_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic last_o
);

  logic [DMA_WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = DMA_WAIT_W'(WAIT_STATES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DMA_WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/dma_copy.sv
// Word-granular block-copy bus initiator; each word is a read strobe then a write strobe,
// each held 1+WAIT_STATES cycles. Grant is rechecked only between words. Fill mode: DMA_COPY_FILL_EN.
module dma_copy
  import dma_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [31:0] len,
`ifdef DMA_COPY_FILL_EN
  input  logic        fill,
  input  logic [31:0] fill_val,
`endif
  output logic        busy,
  output logic        done,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] addr_out,
  output logic        addr_oe,
  output logic [31:0] data_out,
  output logic        data_oe,
  input  logic [31:0] data_in,
  output logic        mem_read,
  output logic        mem_write
);

  dma_state_t           state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [DMA_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          data_q, data_d;
  logic                 fill_q;
  logic                 wait_load;
  logic                 wait_last;

`ifdef DMA_COPY_FILL_EN
  logic fill_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
    end
  end
`else
  assign fill_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef DMA_COPY_FILL_EN
    fill_d  = fill_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src;
          dst_d = dst;
          cnt_d = word_count(len);
`ifdef DMA_COPY_FILL_EN
          fill_d = fill;
          // The fill pattern rides in the data register so WR needs no extra mux.
          if (fill) begin
            data_d = fill_val;
          end
`endif
          state_d = (word_count(len) == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = fill_q ? WR : RD;
        end
      end
      RD: begin
        if (wait_last) begin
          data_d  = data_in;
          state_d = WR;
        end
      end
      WR: begin
        if (wait_last) begin
          src_d = src_q + 32'(DMA_WORD_BYTES);
          dst_d = dst_q + 32'(DMA_WORD_BYTES);
          cnt_d = cnt_q - DMA_CNT_W'(1);
          if (cnt_q == DMA_CNT_W'(1)) begin
            state_d = DONE;
          end else if (bus_gnt) begin
            state_d = fill_q ? WR : RD;
          end else begin
            state_d = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Reload on every new strobe phase, including WR->WR back-to-back fill words.
  assign wait_load = ((state_d == RD) || (state_d == WR)) &&
                     ((state_d != state_q) || wait_last);

  dma_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .load_i(wait_load),
    .last_o(wait_last)
  );

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    bus_req   = (state_q == REQ) || (state_q == RD) || (state_q == WR);
    addr_oe   = (state_q == RD) || (state_q == WR);
    data_oe   = (state_q == WR);
    mem_read  = (state_q == RD);
    mem_write = (state_q == WR);
    addr_out  = '0;
    data_out  = '0;
    if (state_q == RD) begin
      addr_out = src_q;
    end else if (state_q == WR) begin
      addr_out = dst_q;
      data_out = data_q;
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: randomized copies against a word-array reference model of ascending copy.
module tb_dma_copy;

  localparam int WS   = 2;
  localparam int SLOT = 1 + WS;
  localparam int MW   = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [31:0] len = '0;
  logic        bus_gnt = 1'b0;
  logic [31:0] data_in = '0;
`ifdef DMA_COPY_FILL_EN
  logic        fill = 1'b0;
  logic [31:0] fill_val = '0;
`endif
  logic        busy, done, bus_req, addr_oe, data_oe, mem_read, mem_write;
  logic [31:0] addr_out, data_out;

  always #5 clk = ~clk;

  dma_copy #(.WAIT_STATES(WS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
`ifdef DMA_COPY_FILL_EN
    .fill     (fill),
    .fill_val (fill_val),
`endif
    .busy     (busy),
    .done     (done),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .addr_out (addr_out),
    .addr_oe  (addr_oe),
    .data_out (data_out),
    .data_oe  (data_oe),
    .data_in  (data_in),
    .mem_read (mem_read),
    .mem_write(mem_write)
  );

  // Memory aliases modulo 1 KiB; the model uses the same aliasing.
  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  int n_checks = 0;
  int n_pass   = 0;
  int rd_cyc, wr_cyc, req_cyc;

  // One cycle of bus service at the falling edge: memory write, strobe counts, read data.
  task automatic tick();
    @(negedge clk);
    if (mem_write && data_oe) mem[addr_out[9:2]] = data_out;
    rd_cyc  += int'(mem_read);
    wr_cyc  += int'(mem_write);
    req_cyc += int'(bus_req);
    data_in = mem_read ? mem[addr_out[9:2]] : $urandom;
  endtask

  task automatic snap();
    for (int i = 0; i < MW; i++) ref_mem[i] = mem[i];
  endtask

  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    logic [31:0] sa, da;
    for (int i = 0; i < int'(l >> 2); i++) begin
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      ref_mem[da[9:2]] = ref_mem[sa[9:2]];
    end
  endtask

  function automatic int mem_diff(output int first);
    int n = 0;
    first = 0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (mem[i] !== ref_mem[i]) begin
        n++;
        first = i;
      end
    end
    return n;
  endfunction

  // Start a transfer and run until the done pulse has ended; inject>0 pulses a stray start then.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input int inject, output int k_done, output int done_w);
    int k;
    tick();
    rd_cyc = 0; wr_cyc = 0; req_cyc = 0;
    start = 1'b1; src = s; dst = d; len = l;
    k_done = -1; done_w = 0; k = 0;
    while (k < 400) begin
      tick();
      k++;
      start = (k == inject);
      if (k == inject) begin
        src = $urandom; dst = $urandom; len = 32'h40;
      end
      if (done) begin
        if (k_done < 0) k_done = k;
        done_w++;
      end else if (k_done >= 0 && !busy) begin
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({busy, done, bus_req, addr_oe, data_oe, mem_read, mem_write} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, bus_req, addr_oe, data_oe, mem_read, mem_write});
    else n_pass++;
    n_checks++;
    if (addr_out !== 32'h0 || data_out !== 32'h0)
      $display("FAIL reset_data: addr_out=%h data_out=%h want 0", addr_out, data_out);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL reset_idle: busy=%b bus_req=%b want 0", busy, bus_req);
    else n_pass++;
  endtask

  task automatic test_single_word();
    int kd, dw, nd, first;
    bus_gnt = 1'b1;
    mem[64] = 32'hDEADBEEF;
    snap();
    model_copy(32'h100, 32'h200, 32'd4);
    run_copy(32'h100, 32'h200, 32'd4, 0, kd, dw);
    n_checks++;
    if (mem[128] !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", mem[128]);
    else n_pass++;
    n_checks++;
    if (kd !== 2 + 2 * SLOT || dw !== 1)
      $display("FAIL single_done: at %0d width %0d want at %0d width 1", kd, dw, 2 + 2 * SLOT);
    else n_pass++;
    n_checks++;
    if (rd_cyc !== SLOT || wr_cyc !== SLOT)
      $display("FAIL single_strobes: rd %0d wr %0d want %0d each", rd_cyc, wr_cyc, SLOT);
    else n_pass++;
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0) $display("FAIL single_mem: %0d words differ, idx %0d got %h want %h",
                           nd, first, mem[first], ref_mem[first]);
    else n_pass++;
  endtask

  task automatic test_multi_word(input string tag, input logic [31:0] s,
                                 input logic [31:0] d, input logic [31:0] l);
    int kd, dw, nd, first, nw;
    nw = int'(l >> 2);
    bus_gnt = 1'b1;
    snap();
    model_copy(s, d, l);
    run_copy(s, d, l, 0, kd, dw);
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0) $display("FAIL %s_mem: %0d words differ, idx %0d got %h want %h",
                           tag, nd, first, mem[first], ref_mem[first]);
    else n_pass++;
    n_checks++;
    if (kd !== 2 + 2 * nw * SLOT)
      $display("FAIL %s_latency: done at %0d want %0d", tag, kd, 2 + 2 * nw * SLOT);
    else n_pass++;
    n_checks++;
    if (rd_cyc + wr_cyc !== 2 * nw * SLOT || req_cyc !== 1 + 2 * nw * SLOT)
      $display("FAIL %s_strobes: strobe %0d req %0d want %0d %0d", tag, rd_cyc + wr_cyc,
               req_cyc, 2 * nw * SLOT, 1 + 2 * nw * SLOT);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int kd1, kd2, dw, nd, first;
    logic [31:0] s1, d1, s2, d2;
    s1 = $urandom & 32'hFFFF_FFFC; d1 = $urandom & 32'hFFFF_FFFC;
    s2 = $urandom & 32'hFFFF_FFFC; d2 = $urandom & 32'hFFFF_FFFC;
    bus_gnt = 1'b1;
    snap();
    model_copy(s1, d1, 32'd8);
    model_copy(s2, d2, 32'd12);
    run_copy(s1, d1, 32'd8, 0, kd1, dw);
    run_copy(s2, d2, 32'd12, 0, kd2, dw);
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0) $display("FAIL b2b_mem: %0d words differ, idx %0d got %h want %h",
                           nd, first, mem[first], ref_mem[first]);
    else n_pass++;
    n_checks++;
    if (kd1 !== 2 + 4 * SLOT || kd2 !== 2 + 6 * SLOT)
      $display("FAIL b2b_latency: %0d %0d want %0d %0d", kd1, kd2, 2 + 4 * SLOT, 2 + 6 * SLOT);
    else n_pass++;
  endtask

  task automatic test_grant_withdrawal();
    int words, k, nd, first;
    bit prev_rd, parked, bad, seen_done;
    logic [31:0] s, d;
    s = 32'h0C0; d = 32'h1C0;
    bus_gnt = 1'b1;
    snap();
    model_copy(s, d, 32'd12);
    tick();
    rd_cyc = 0; wr_cyc = 0; req_cyc = 0;
    start = 1'b1; src = s; dst = d; len = 32'd12;
    words = 0; prev_rd = 1'b0; parked = 1'b0;
    for (k = 0; k < 200 && !parked; k++) begin
      tick();
      start = 1'b0;
      if (mem_read && !prev_rd) words++;
      prev_rd = mem_read;
      if (words == 2 && mem_read) bus_gnt = 1'b0;
      parked = !bus_gnt && busy && bus_req && !mem_read && !mem_write;
    end
    n_checks++;
    if (parked !== 1'b1) $display("FAIL grant_park: parked=%b want 1", parked);
    else n_pass++;
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (!(bus_req && busy && !addr_oe && !data_oe && !mem_read && !mem_write)) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL grant_park_hold: drives seen while parked (bad=%b want 0)", bad);
    else n_pass++;
    n_checks++;
    if (rd_cyc !== 2 * SLOT || wr_cyc !== 2 * SLOT)
      $display("FAIL grant_words_done: rd %0d wr %0d want %0d each", rd_cyc, wr_cyc, 2 * SLOT);
    else n_pass++;
    bus_gnt = 1'b1;
    tick();
    n_checks++;
    if (mem_read !== 1'b1 || addr_out !== s + 32'd8)
      $display("FAIL grant_resume: mem_read=%b addr=%h want 1 %h", mem_read, addr_out, s + 32'd8);
    else n_pass++;
    seen_done = 1'b0;
    for (k = 0; k < 200; k++) begin
      tick();
      if (done) seen_done = 1'b1;
      else if (seen_done && !busy) break;
    end
    nd = mem_diff(first);
    n_checks++;
    if (!seen_done || nd !== 0)
      $display("FAIL grant_mem: done=%b, %0d words differ, idx %0d got %h want %h",
               seen_done, nd, first, mem[first], ref_mem[first]);
    else n_pass++;
  endtask

  task automatic test_zero_odd();
    int kd, dw, nd, first;
    logic [31:0] lens [2];
    lens[0] = 32'd0; lens[1] = 32'd3;
    bus_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      snap();
      run_copy($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, lens[i], 0, kd, dw);
      nd = mem_diff(first);
      n_checks++;
      if (kd !== 1 || req_cyc !== 0 || nd !== 0)
        $display("FAIL zero_len_%0d: done at %0d req %0d diff %0d want 1 0 0",
                 lens[i], kd, req_cyc, nd);
      else n_pass++;
    end
    snap();
    model_copy(32'h040, 32'h3C0, 32'd7);
    run_copy(32'h040, 32'h3C0, 32'd7, 0, kd, dw);
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0 || rd_cyc !== SLOT || kd !== 2 + 2 * SLOT)
      $display("FAIL odd_len_7: diff %0d rd %0d done at %0d want 0 %0d %0d",
               nd, rd_cyc, kd, SLOT, 2 + 2 * SLOT);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int writes, k, kd, dw, nd, first;
    bit prev_wr;
    bus_gnt = 1'b1;
    snap();
    model_copy(32'h000, 32'h100, 32'd12);
    tick();
    start = 1'b1; src = 32'h000; dst = 32'h100; len = 32'd12;
    writes = 0; prev_wr = 1'b0;
    for (k = 0; k < 200 && writes < 3; k++) begin
      tick();
      start = 1'b0;
      if (mem_write && !prev_wr) writes++;
      prev_wr = mem_write;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, bus_req, addr_oe, data_oe, mem_read, mem_write} !== 7'b0 ||
        addr_out !== 32'h0 || data_out !== 32'h0)
      $display("FAIL reset_mid_outputs: ctrl %b addr %h data %h want all 0 (writes seen %0d)",
               {busy, done, bus_req, addr_oe, data_oe, mem_read, mem_write},
               addr_out, data_out, writes);
    else n_pass++;
    n_checks++;
    if (mem[64] !== ref_mem[64] || mem[65] !== ref_mem[65])
      $display("FAIL reset_mid_words: got %h %h want %h %h", mem[64], mem[65],
               ref_mem[64], ref_mem[65]);
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    snap();
    model_copy(32'h200, 32'h280, 32'd8);
    run_copy(32'h200, 32'h280, 32'd8, 0, kd, dw);
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0 || kd !== 2 + 4 * SLOT)
      $display("FAIL reset_mid_restart: diff %0d done at %0d want 0 %0d", nd, kd, 2 + 4 * SLOT);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int kd, dw, nd, first;
    logic [31:0] s, d;
    s = $urandom & 32'hFFFF_FFFC; d = $urandom & 32'hFFFF_FFFC;
    bus_gnt = 1'b1;
    snap();
    model_copy(s, d, 32'd12);
    run_copy(s, d, 32'd12, 3, kd, dw);
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0 || kd !== 2 + 6 * SLOT || dw !== 1)
      $display("FAIL start_busy: diff %0d done at %0d width %0d want 0 %0d 1",
               nd, kd, dw, 2 + 6 * SLOT);
    else n_pass++;
  endtask

`ifdef DMA_COPY_FILL_EN
  task automatic test_fill();
    int kd, dw, nd, first;
    bus_gnt = 1'b1;
    fill = 1'b1; fill_val = 32'hA5A5A5A5;
    snap();
    ref_mem[192] = 32'hA5A5A5A5;
    ref_mem[193] = 32'hA5A5A5A5;
    run_copy(32'h000, 32'h300, 32'd8, 0, kd, dw);
    fill = 1'b0;
    nd = mem_diff(first);
    n_checks++;
    if (nd !== 0) $display("FAIL fill_mem: %0d words differ, idx %0d got %h want %h",
                           nd, first, mem[first], ref_mem[first]);
    else n_pass++;
    n_checks++;
    if (rd_cyc !== 0 || kd !== 2 + 2 * SLOT)
      $display("FAIL fill_timing: rd %0d done at %0d want 0 %0d", rd_cyc, kd, 2 + 2 * SLOT);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < MW; i++) mem[i] = $urandom;
    test_reset();
    test_single_word();
    test_multi_word("multi_ws", 32'h000, 32'h040, 32'd16);
    test_multi_word("overlap", 32'h180, 32'h184, 32'd20);
    test_multi_word("wrap", 32'hFFFF_FFF8, 32'h2C0, 32'd16);
    for (int r = 0; r < 3; r++)
      test_multi_word("random", $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                      32'($urandom_range(4, 40)));
    test_back_to_back();
    test_grant_withdrawal();
    test_zero_odd();
    test_reset_mid();
    test_start_while_busy();
`ifdef DMA_COPY_FILL_EN
    test_fill();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
